regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general register file. Successor to the 2-read/1-write 32x32 GRF in the MIPS pipeline.
- Adds configurable width, depth and read/write port counts.
- Adds a per-register pending scoreboard, for hazard detection in ID.
- Adds a sequenced soft-clear engine with busy/done handshake.
- Sits in the decode stage. Write ports are driven from WB (and optionally a second writeback lane).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of asynchronous read ports
- NUM_WR, 1, number of write ports (1..4)
- ZERO_REG, 1, 1 = entry 0 hardwired to zero, writes/allocs to it ignored

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- raddr  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  pending flag of register addressed by port k
- we  in  NUM_WR  write enable per write port
- waddr  in  NUM_WR*ADDR_W  write indices
- wdata  in  NUM_WR*DATA_W  write data
- alloc_en  in  1  mark alloc_addr pending (producer issued)
- alloc_addr  in  ADDR_W  register to mark
- clr_req  in  1  start soft clear sweep (single-cycle pulse)
- busy  out  1  sweep in progress; writes/allocs ignored
- clr_done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Reset (sync, clk edge with reset=1):
  - All DEPTH entries are set to 0 in that cycle.
  - All pend bits are set to 0.
  - FSM goes to IDLE; busy=0, clr_done=0.
  - Reset during a sweep aborts the sweep; no clr_done pulse.
- Writes (IDLE only):
  - On the clk edge, entry waddr[i] <= wdata[i] for each i with we[i]=1.
  - If several enabled ports target the same address, the highest port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Purely combinational.
  - rdata[k] = 0 if ZERO_REG and raddr[k]==0; otherwise bypass value (see Optional Feature); otherwise stored entry.
- Scoreboard:
  - alloc_en sets pend[alloc_addr] at the edge.
  - An enabled write to address a clears pend[a] at the edge.
  - Alloc and write to the same address in the same cycle: pend stays 1 (newer producer wins).
  - pend[0] is always 0 when ZERO_REG=1.
  - rd_pend[k] = pend[raddr[k]], adjusted per Optional Feature.
- Clear FSM, states IDLE and SWEEP:
  - IDLE, clr_req=1: go to SWEEP, ptr<=0, busy=1 from the next cycle.
  - SWEEP: each cycle, entry[ptr]<=0 and pend[ptr]<=0, then ptr<=ptr+1.
  - When ptr==DEPTH-1 is cleared, return to IDLE. On that same edge busy goes 0 and clr_done pulses high for 1 cycle.
  - Sweep takes exactly DEPTH cycles.
  - During SWEEP, we, alloc_en and clr_req are ignored.
  - Reads still return current storage (partially cleared contents are visible) and bypass is disabled.
- Widths: all index and data arithmetic is unsigned. ptr is ADDR_W bits and wraps naturally at DEPTH-1.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined, IDLE state:
  - If any enabled write targets raddr[k] (nonzero when ZERO_REG), rdata[k] returns the winning port's wdata in the same cycle.
  - rd_pend[k] is forced 0 unless alloc_en targets the same address.
- Undefined: rdata returns stored contents only (new value visible next cycle), and rd_pend is raw pend.

Decomposition:
- Shared package regfile_pkg:
  - FSM state typedef (RF_IDLE, RF_SWEEP).
  - Default width constants DATA_W_DEF=32 and ADDR_W_DEF=5.
  - Function computing the winning write port for an address (highest index).
- One natural sub-module, rf_read_port, instantiated NUM_RD times. It takes one raddr, the storage array view, and the write-port buses, and produces rdata/rd_pend including bypass and zero-register logic.

Test Plan:
- Reset then read: reset 1 cycle, read addr 5 and 31 -> rdata 0, rd_pend 0, busy 0.
- Write then read: we[0]=1, waddr=3, wdata=32'hDEADBEEF; next cycle raddr=3 -> DEADBEEF. Same-cycle read of 3 -> DEADBEEF with RF_BYPASS_EN, old value without it.
- Zero register: write 32'h1234 to addr 0 -> read 0 returns 0. alloc_addr=0 -> rd_pend 0.
- Write conflict: NUM_WR=2, both ports write addr 7 with 32'h11 and 32'h22 -> entry 7 = 32'h22.
- Scoreboard:
  - alloc_en addr 9 -> rd_pend=1 next cycle.
  - Write 9 -> pend cleared next cycle.
  - Simultaneous alloc+write on 9 -> stays pending.
- Soft clear:
  - Fill all entries with 32'hA5A5A5A5, pulse clr_req.
  - busy high for 32 cycles; writes during the sweep are dropped.
  - clr_done pulses once; all reads 0 afterwards.
  - Reset asserted at sweep cycle 10 -> all entries 0, no clr_done.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file (regfile_mp):
//   - rf_state_e  : soft-clear engine states (RF_IDLE, RF_SWEEP)
//   - DATA_W_DEF / ADDR_W_DEF : default register width / index width
//   - MAX_WR      : upper bound on the number of write ports
//   - rf_win_port : picks the winning write port (highest index) from a
//                   per-port hit vector
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_WR     = 4;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] port;
    } rf_win_t;

    // Later ports overwrite earlier ones, so the highest enabled index wins.
    function automatic rf_win_t rf_win_port(input logic [MAX_WR-1:0] hit);
        rf_win_t win;
        win = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (hit[p]) begin
                win.valid = 1'b1;
                win.port  = 2'(p);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of regfile_mp, with zero-register handling and
// (when RF_BYPASS_EN is defined) same-cycle write bypass.
// Ports:
//   i_raddr              read index
//   i_mem / i_pend       current storage contents and pending bits
//   i_idle               clear engine idle (bypass only allowed then)
//   i_we/i_waddr/i_wdata write-port buses (bypass source)
//   i_alloc_en/addr      scoreboard allocation in the same cycle
//   o_rdata / o_rd_pend  read data and pending flag for i_raddr
// Macro: RF_BYPASS_EN enables the write bypass.
// -----------------------------------------------------------------------------
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2**ADDR_W
)(
    input  logic [ADDR_W-1:0]        i_raddr,
    input  logic [DATA_W-1:0]        i_mem [DEPTH],
    input  logic [DEPTH-1:0]         i_pend,
    input  logic                     i_idle,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*DATA_W-1:0] i_wdata,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_rd_pend
);

    logic w_zero_hit;
    assign w_zero_hit = (ZERO_REG != 0) && (i_raddr == '0);

`ifdef RF_BYPASS_EN
    logic [MAX_WR-1:0] w_hit;
    logic [DATA_W-1:0] w_wd [MAX_WR];
    rf_win_t           w_win;
    logic              w_byp;

    genvar gi;
    for (gi = 0; gi < MAX_WR; gi++) begin : g_pad
        if (gi < NUM_WR) begin : g_live
            assign w_hit[gi] = i_we[gi] && (i_waddr[gi*ADDR_W +: ADDR_W] == i_raddr);
            assign w_wd[gi]  = i_wdata[gi*DATA_W +: DATA_W];
        end else begin : g_tie
            assign w_hit[gi] = 1'b0;
            assign w_wd[gi]  = '0;
        end
    end

    assign w_win = rf_win_port(w_hit);
    assign w_byp = i_idle && w_win.valid;

    always_comb begin
        o_rdata   = i_mem[i_raddr];
        o_rd_pend = i_pend[i_raddr];
        if (w_byp) begin
            // The write retires the producer this cycle, unless a newer
            // producer is being allocated to the same register right now.
            o_rdata   = w_wd[w_win.port];
            o_rd_pend = i_alloc_en && (i_alloc_addr == i_raddr);
        end
        if (w_zero_hit) begin
            o_rdata   = '0;
            o_rd_pend = 1'b0;
        end
    end
`else
    // Write/alloc buses only feed the bypass path.
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_idle, i_we, i_waddr, i_wdata, i_alloc_en, i_alloc_addr};

    always_comb begin
        o_rdata   = i_mem[i_raddr];
        o_rd_pend = i_pend[i_raddr];
        if (w_zero_hit) begin
            o_rdata   = '0;
            o_rd_pend = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port general register file for the decode stage, with a
// per-register pending scoreboard and a sequenced soft-clear engine.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   raddr/rdata/rd_pend   NUM_RD asynchronous read ports (packed buses)
//   we/waddr/wdata        NUM_WR write ports, highest index wins on conflict
//   alloc_en/alloc_addr   mark a register pending (producer issued)
//   clr_req               start a DEPTH-cycle sweep clearing data and pend
//   busy                  sweep in progress (writes/allocs ignored)
//   clr_done              one-cycle pulse at sweep completion
// Macro: RF_BYPASS_EN enables same-cycle write-to-read bypass.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_e         r_state;
    rf_state_e         w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_clr_done;
    logic              w_idle;
    logic              w_sweep;

    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DEPTH-1:0]  w_pend;

    logic [MAX_WR-1:0] w_we_pad;
    logic [ADDR_W-1:0] w_waddr_pad [MAX_WR];
    logic [DATA_W-1:0] w_wdata_pad [MAX_WR];

    assign w_idle  = (r_state == RF_IDLE);
    assign w_sweep = (r_state == RF_SWEEP);

    genvar gi;

    // Pad the write buses to MAX_WR ports so the winner function is fixed-size.
    for (gi = 0; gi < MAX_WR; gi++) begin : g_wpad
        if (gi < NUM_WR) begin : g_live
            assign w_we_pad[gi]    = we[gi];
            assign w_waddr_pad[gi] = waddr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_pad[gi] = wdata[gi*DATA_W +: DATA_W];
        end else begin : g_tie
            assign w_we_pad[gi]    = 1'b0;
            assign w_waddr_pad[gi] = '0;
            assign w_wdata_pad[gi] = '0;
        end
    end

    // ---------------- Clear engine ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RF_IDLE:  if (clr_req)       w_state_next = RF_SWEEP;
            RF_SWEEP: if (r_ptr == '1)   w_state_next = RF_IDLE;
            default:                     w_state_next = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RF_IDLE;
            r_ptr      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_done <= w_sweep && (r_ptr == '1);
            if (w_idle && clr_req) begin
                r_ptr <= '0;
            end else if (w_sweep) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign busy     = w_sweep;
    assign clr_done = r_clr_done;

    // ---------------- Storage and scoreboard, one slice per entry ----------------
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DATA_W-1:0] r_entry;
        logic              r_pend;
        logic [MAX_WR-1:0] w_hit;
        rf_win_t           w_win;
        logic              w_frozen;
        logic              w_alloc_hit;
        logic              w_sweep_hit;

        // Entry 0 is hardwired to zero: it never accepts writes or allocs.
        assign w_frozen    = (ZERO_REG != 0) && (gi == 0);
        assign w_alloc_hit = alloc_en && (alloc_addr == ADDR_W'(gi));
        assign w_sweep_hit = w_sweep && (r_ptr == ADDR_W'(gi));

        always_comb begin
            w_hit = '0;
            for (int p = 0; p < MAX_WR; p++) begin
                w_hit[p] = w_we_pad[p] && (w_waddr_pad[p] == ADDR_W'(gi));
            end
        end

        assign w_win = rf_win_port(w_hit);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_entry <= '0;
                r_pend  <= 1'b0;
            end else if (w_sweep_hit) begin
                r_entry <= '0;
                r_pend  <= 1'b0;
            end else if (w_idle && !w_frozen) begin
                if (w_win.valid) begin
                    r_entry <= w_wdata_pad[w_win.port];
                end
                // A new producer allocated this cycle outranks the retiring one.
                if (w_alloc_hit) begin
                    r_pend <= 1'b1;
                end else if (w_win.valid) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign w_mem[gi]  = r_entry;
        assign w_pend[gi] = r_pend;
    end

    // ---------------- Read ports ----------------
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .i_raddr      (raddr[gi*ADDR_W +: ADDR_W]),
            .i_mem        (w_mem),
            .i_pend       (w_pend),
            .i_idle       (w_idle),
            .i_we         (we),
            .i_waddr      (waddr),
            .i_wdata      (wdata),
            .i_alloc_en   (alloc_en),
            .i_alloc_addr (alloc_addr),
            .o_rdata      (rdata[gi*DATA_W +: DATA_W]),
            .o_rd_pend    (rd_pend[gi])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp (NUM_WR=2, NUM_RD=2, 32x32, ZERO_REG=1).
// A behavioural model (arrays + sweep index) predicts every output each cycle;
// directed phases follow the test plan, then a randomized phase runs.
// Honours RF_BYPASS_EN in its model when the macro is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rd_pend;
    logic [NWR-1:0]    we;
    logic [NWR*AW-1:0] waddr;
    logic [NWR*DW-1:0] wdata;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    logic [AW-1:0] ra [NRD];
    logic [AW-1:0] wa [NWR];
    logic [DW-1:0] wd [NWR];

    assign raddr = {ra[1], ra[0]};
    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .rdata      (rdata),
        .rd_pend    (rd_pend),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .busy       (busy),
        .clr_done   (clr_done)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_busy;
    bit            m_done;
    int            m_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_busy = 0;
    int obs_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
`ifdef RF_BYPASS_EN
        if (!m_busy)
            for (int p = 0; p < NWR; p++)
                if (we[p] && wa[p] == a) v = wd[p];
`endif
        return v;
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] a);
        bit v;
        if (a == 0) return 1'b0;
        v = m_pend[a];
`ifdef RF_BYPASS_EN
        if (!m_busy)
            for (int p = 0; p < NWR; p++)
                if (we[p] && wa[p] == a) v = alloc_en && (alloc_addr == a);
`endif
        return v;
    endfunction

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_mem[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            m_done        = (m_idx == DEPTH - 1);
            if (m_idx == DEPTH - 1) m_busy = 1'b0;
            else                    m_idx++;
        end else begin
            m_done = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa[p] != 0) begin
                    m_mem[wa[p]]  = wd[p];
                    m_pend[wa[p]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rdata%0d[a=%0d]", k, ra[k]), rdata[k*DW +: DW], exp_rdata(ra[k]));
            chk($sformatf("rd_pend%0d[a=%0d]", k, ra[k]), 32'(rd_pend[k]), 32'(exp_pend(ra[k])));
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        obs_busy += int'(busy);
        obs_done += int'(clr_done);
    endtask

    // One clock transaction: check at the falling edge, update model at the rising edge.
    task automatic step(input string what);
        @(negedge clk);
        check_outputs();
        if (what.len() > 0)
            $display("[%0t] %s we=%b wa0=%0d wa1=%0d ra0=%0d ra1=%0d rd0=%h busy=%b",
                     $time, what, we, wa[0], wa[1], ra[0], ra[1], rdata[DW-1:0], busy);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        we       = '0;
        alloc_en = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic fill_all(input logic [DW-1:0] val);
        for (int a = 0; a < DEPTH; a += 2) begin
            we = 2'b11; wa[0] = AW'(a); wa[1] = AW'(a + 1);
            wd[0] = val; wd[1] = val;
            step("");
        end
        idle_inputs();
    endtask

    task automatic readback_zero(input string tag);
        for (int a = 0; a < DEPTH; a += 2) begin
            ra[0] = AW'(a); ra[1] = AW'(a + 1);
            step("");
            chk($sformatf("%s_a%0d", tag, a),     rdata[DW-1:0],     32'h0);
            chk($sformatf("%s_a%0d", tag, a + 1), rdata[2*DW-1:DW], 32'h0);
        end
    endtask

    initial begin
        ra[0] = 5; ra[1] = 31;
        wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
        alloc_addr = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;

        // Reset then read
        step("reset_read");
        chk("rst_rd5", rdata[DW-1:0], 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Write then read
        we = 2'b01; wa[0] = 3; wd[0] = 32'hDEADBEEF; ra[0] = 3;
        step("wr3_samecycle");
        idle_inputs();
        step("rd3");
        chk("wr3_readback", rdata[DW-1:0], 32'hDEADBEEF);

        // Zero register
        we = 2'b01; wa[0] = 0; wd[0] = 32'h1234; alloc_en = 1'b1; alloc_addr = 0; ra[0] = 0;
        step("wr0_alloc0");
        idle_inputs();
        step("rd0");
        chk("zero_rdata", rdata[DW-1:0], 32'h0);
        chk("zero_pend", 32'(rd_pend[0]), 32'h0);

        // Write conflict
        we = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'h11; wd[1] = 32'h22;
        step("conflict7");
        idle_inputs(); ra[0] = 7;
        step("rd7");
        chk("conflict7", rdata[DW-1:0], 32'h22);

        // Scoreboard
        alloc_en = 1'b1; alloc_addr = 9; ra[0] = 9;
        step("alloc9");
        idle_inputs();
        step("pend9");
        chk("pend9_set", 32'(rd_pend[0]), 32'h1);
        we = 2'b01; wa[0] = 9; wd[0] = 32'h99;
        step("wr9");
        idle_inputs();
        step("pend9");
        chk("pend9_clr", 32'(rd_pend[0]), 32'h0);
        we = 2'b01; wa[0] = 9; wd[0] = 32'h98; alloc_en = 1'b1; alloc_addr = 9;
        step("alloc_wr9");
        idle_inputs();
        step("pend9");
        chk("pend9_keep", 32'(rd_pend[0]), 32'h1);

        // Soft clear: full sweep with writes/allocs attempted during it
        fill_all(32'hA5A5A5A5);
        obs_busy = 0; obs_done = 0;
        clr_req = 1'b1;
        step("clr_req");
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                we = 2'($urandom); wa[0] = AW'($urandom); wa[1] = AW'($urandom);
                wd[0] = $urandom; wd[1] = $urandom;
                alloc_en = 1'($urandom); alloc_addr = AW'($urandom);
                clr_req = 1'($urandom);
            end else begin
                idle_inputs();
            end
            ra[0] = AW'($urandom); ra[1] = AW'($urandom);
            step("");
        end
        chk("sweep_busy_cycles", 32'(obs_busy), 32'd32);
        chk("sweep_done_pulses", 32'(obs_done), 32'd1);
        readback_zero("swept");

        // Reset aborting a sweep at cycle 10
        fill_all(32'hA5A5A5A5);
        obs_done = 0;
        clr_req = 1'b1;
        step("clr_req");
        clr_req = 1'b0;
        repeat (10) step("");
        reset = 1'b1;
        step("abort_reset");
        reset = 1'b0;
        readback_zero("aborted");
        chk("abort_no_done", 32'(obs_done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            we       = 2'($urandom);
            wa[0]    = AW'($urandom_range(0, 7));
            wa[1]    = AW'($urandom_range(0, 7));
            wd[0]    = $urandom;
            wd[1]    = $urandom;
            alloc_en = ($urandom_range(0, 3) == 0);
            alloc_addr = AW'($urandom_range(0, 7));
            clr_req  = ($urandom_range(0, 99) == 0);
            ra[0]    = AW'($urandom_range(0, 9));
            ra[1]    = AW'($urandom_range(0, 31));
            step("");
        end
        idle_inputs();
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
